// File: rtl/nexys_btn_stepper.sv
// Button-driven single-step clock source: synchronizes and debounces BTND, then issues
// one-cycle step strobes (with optional auto-repeat), a stretched step clock and a step count.
module nexys_btn_stepper #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic        CLK100,
  input  logic        resetn,
  input  logic        BTND,
  input  logic        repeat_en_i,
  output logic        btn_level_o,
  output logic        step_o,
  output logic        step_clk_o,
  output logic [15:0] step_count_o
);

  localparam int unsigned DcntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HcntW   = $clog2(HoldMax + 1);
  localparam int unsigned PcntW   = $clog2(PULSE_CYCLES + 1);

  localparam logic [DcntW-1:0] DcntLast   = DcntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HcntW-1:0] DelayLast  = HcntW'(REPEAT_DELAY - 1);
  localparam logic [HcntW-1:0] PeriodLast = HcntW'(REPEAT_PERIOD - 1);
  localparam logic [PcntW-1:0] PulseLoad  = PcntW'(PULSE_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } state_e;

  logic             sync1_q;
  logic             btn_sync_q;
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             level_rise;
  logic             level_fall;

  state_e           state_q;
  logic [HcntW-1:0] hcnt_q;
  logic [PcntW-1:0] pcnt_q;
  logic             step_q;
  logic [15:0]      count_q;

  // Two-flop synchronizer; BTND is asynchronous to CLK100.
  always_ff @(posedge CLK100 or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      sync1_q    <= BTND;
      btn_sync_q <= sync1_q;
    end
  end

  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    if (btn_sync_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DcntLast) begin
      dcnt_d  = '0;
      level_d = ~level_q;
    end else begin
      dcnt_d = dcnt_q + DcntW'(1);
    end
  end

  always_ff @(posedge CLK100 or negedge resetn) begin
    if (!resetn) begin
      dcnt_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      dcnt_q       <= dcnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level_rise = level_q & ~level_prev_q;
  // A fall on this edge must already block a step that would otherwise be due now.
  assign level_fall = level_q & ~level_d;

  always_ff @(posedge CLK100 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (pcnt_q != '0) begin
        pcnt_q <= pcnt_q - PcntW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (level_rise && !level_fall) begin
            step_q  <= 1'b1;
            pcnt_q  <= PulseLoad;
            hcnt_q  <= '0;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (!level_q || level_fall) begin
            state_q <= StIdle;
          end else if (hcnt_q == DelayLast) begin
            // Without repeat enabled the count parks here until enabled or released.
            if (repeat_en_i) begin
              step_q  <= 1'b1;
              pcnt_q  <= PulseLoad;
              hcnt_q  <= '0;
              state_q <= StRepeat;
            end
          end else begin
            hcnt_q <= hcnt_q + HcntW'(1);
          end
        end
        StRepeat: begin
          if (!level_q || level_fall) begin
            state_q <= StIdle;
          end else if (hcnt_q == PeriodLast) begin
            if (repeat_en_i) begin
              step_q <= 1'b1;
              pcnt_q <= PulseLoad;
              hcnt_q <= '0;
            end
          end else begin
            hcnt_q <= hcnt_q + HcntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK100 or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (step_q) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign btn_level_o  = level_q;
  assign step_o       = step_q;
  assign step_clk_o   = (pcnt_q != '0);
  assign step_count_o = count_q;

endmodule

// File: tb/tb_nexys_btn_stepper.sv
// Directed bench for nexys_btn_stepper with short debounce/pulse/repeat timings.
module tb_nexys_btn_stepper;

  logic        CLK100 = 1'b0;
  logic        resetn = 1'b1;
  logic        BTND = 1'b0;
  logic        repeat_en = 1'b0;
  logic        btn_level;
  logic        step;
  logic        step_clk;
  logic [15:0] step_count;

  int checks = 0;
  int errors = 0;

  // Filled by run_log; ticks are numbered from 1 = first edge after the call.
  int rise_at, fall_at, nsteps, clk_high, cnt_next;
  int step_at[16];
  int exp_steps[6] = '{7, 27, 35, 43, 51, 59};

  nexys_btn_stepper #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (2),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .CLK100      (CLK100),
    .resetn      (resetn),
    .BTND        (BTND),
    .repeat_en_i (repeat_en),
    .btn_level_o (btn_level),
    .step_o      (step),
    .step_clk_o  (step_clk),
    .step_count_o(step_count)
  );

  always #5 CLK100 = ~CLK100;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK100);
    #1;
  endtask

  task automatic run_log(input int n, input int release_at);
    logic prev;
    prev     = btn_level;
    rise_at  = -1;
    fall_at  = -1;
    nsteps   = 0;
    clk_high = 0;
    cnt_next = -1;
    for (int k = 0; k < 16; k++) step_at[k] = -1;
    for (int i = 1; i <= n; i++) begin
      if (i == release_at) BTND = 1'b0;
      tick();
      if (btn_level && !prev && rise_at < 0) rise_at = i;
      if (!btn_level && prev && fall_at < 0) fall_at = i;
      prev = btn_level;
      if (nsteps >= 1 && i == step_at[0] + 1) cnt_next = int'(step_count);
      if (step) begin
        if (nsteps < 16) step_at[nsteps] = i;
        nsteps++;
      end
      if (step_clk) clk_high++;
    end
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      BTND = i[0];
      tick();
      checks++;
      if ({btn_level, step, step_clk, step_count} !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs: got %0h, expected 0", {btn_level, step, step_clk, step_count});
      end
    end
    BTND = 1'b0;
    @(negedge CLK100);
    resetn = 1'b1;
    run_log(100, 0);
    checks++;
    if (nsteps !== 0) begin
      errors++;
      $display("FAIL reset_idle_steps: got %0d, expected 0", nsteps);
    end
    checks++;
    if (rise_at !== -1) begin
      errors++;
      $display("FAIL reset_idle_level: got rise at %0d, expected none (-1)", rise_at);
    end
  endtask

  task automatic test_clean_press();
    BTND = 1'b1;
    run_log(30, 0);
    checks++;
    if (rise_at !== 6) begin
      errors++;
      $display("FAIL press_level_rise: got %0d, expected 6", rise_at);
    end
    checks++;
    if (step_at[0] !== 7) begin
      errors++;
      $display("FAIL press_step_time: got %0d, expected 7", step_at[0]);
    end
    checks++;
    if (nsteps !== 1) begin
      errors++;
      $display("FAIL press_step_count: got %0d, expected 1", nsteps);
    end
    checks++;
    if (clk_high !== 2) begin
      errors++;
      $display("FAIL press_clk_high: got %0d, expected 2", clk_high);
    end
    checks++;
    if (cnt_next !== 1) begin
      errors++;
      $display("FAIL press_count_after_step: got %0d, expected 1", cnt_next);
    end
    run_log(15, 1);
    checks++;
    if (fall_at !== 6) begin
      errors++;
      $display("FAIL release_level_fall: got %0d, expected 6", fall_at);
    end
    checks++;
    if (nsteps !== 0) begin
      errors++;
      $display("FAIL release_steps: got %0d, expected 0", nsteps);
    end
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      BTND = (i % 4 != 3);
      tick();
      if (btn_level !== 1'b0 || step !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bounce_level: got %0d active cycles, expected 0", bad);
    end
    BTND = 1'b1;
    run_log(30, 0);
    checks++;
    if (rise_at !== 6 || step_at[0] !== 7 || nsteps !== 1) begin
      errors++;
      $display("FAIL bounce_settle: got rise %0d step %0d n %0d, expected 6 7 1",
               rise_at, step_at[0], nsteps);
    end
    checks++;
    if (step_count !== 16'd2) begin
      errors++;
      $display("FAIL bounce_count: got %0d, expected 2", step_count);
    end
    run_log(15, 1);
  endtask

  task automatic test_auto_repeat();
    int rel[3] = '{61, 55, 62};
    int fall_exp[3] = '{66, 60, 67};
    repeat_en = 1'b1;
    for (int s = 0; s < 3; s++) begin
      BTND = 1'b1;
      run_log(80, rel[s]);
      checks++;
      if (fall_at !== fall_exp[s]) begin
        errors++;
        $display("FAIL repeat%0d_fall: got %0d, expected %0d", s, fall_at, fall_exp[s]);
      end
      checks++;
      if (nsteps !== 6) begin
        errors++;
        $display("FAIL repeat%0d_nsteps: got %0d, expected 6", s, nsteps);
      end
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (step_at[k] !== exp_steps[k]) begin
          errors++;
          $display("FAIL repeat%0d_step%0d: got %0d, expected %0d", s, k, step_at[k], exp_steps[k]);
        end
      end
      checks++;
      if (clk_high !== 12) begin
        errors++;
        $display("FAIL repeat%0d_clk_high: got %0d, expected 12", s, clk_high);
      end
      checks++;
      if (int'(step_count) !== 2 + 6 * (s + 1)) begin
        errors++;
        $display("FAIL repeat%0d_count: got %0d, expected %0d", s, step_count, 2 + 6 * (s + 1));
      end
    end
    repeat_en = 1'b0;
  endtask

  task automatic test_wrap();
    repeat_en = 1'b1;
    BTND = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    tick();
    checks++;
    if (step !== 1'b1 || step_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got step %0d count %0h, expected 1 ffff", step, step_count);
    end
    tick();
    checks++;
    if (step_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: got %0h, expected 0000", step_count);
    end
    for (int i = 9; i <= 28; i++) tick();
    checks++;
    if (step_count !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_one: got %0h, expected 0001", step_count);
    end
    run_log(20, 1);
    repeat_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat_en = 1'b1;
    BTND = 1'b1;
    for (int i = 1; i <= 27; i++) tick();
    checks++;
    if (step !== 1'b1 || step_clk !== 1'b1) begin
      errors++;
      $display("FAIL mid_precondition: got step %0d clk %0d, expected 1 1", step, step_clk);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({btn_level, step, step_clk, step_count} !== 19'd0) begin
      errors++;
      $display("FAIL mid_async_clear: got %0h, expected 0", {btn_level, step, step_clk, step_count});
    end
    repeat_en = 1'b0;
    @(negedge CLK100);
    resetn = 1'b1;
    run_log(30, 0);
    checks++;
    if (rise_at !== 6 || step_at[0] !== 7 || nsteps !== 1) begin
      errors++;
      $display("FAIL mid_fresh_press: got rise %0d step %0d n %0d, expected 6 7 1",
               rise_at, step_at[0], nsteps);
    end
    checks++;
    if (step_count !== 16'd1) begin
      errors++;
      $display("FAIL mid_count: got %0d, expected 1", step_count);
    end
    run_log(15, 1);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
